// File: rtl/quad_decoder_if.sv
// quad_decoder_if
// Groups the encoder-side inputs and the decoded position/status outputs of
// the quadrature decoder into one bundle.
//   enc_a, enc_b : raw encoder channels, asynchronous to the decoder clock
//   clr          : synchronous clear of pos and err, active high
//   pos          : wrapping up/down position count
//   dir          : direction of the last legal step (1 = up)
//   step         : one-cycle pulse per legal transition
//   err          : sticky illegal-transition flag
// Modports: master drives the encoder/clear side, slave is the decoder.
interface quad_decoder_if #(
    parameter int POS_W = 8
);
    logic             enc_a;
    logic             enc_b;
    logic             clr;
    logic [POS_W-1:0] pos;
    logic             dir;
    logic             step;
    logic             err;

    modport master (
        output enc_a, enc_b, clr,
        input  pos, dir, step, err
    );

    modport slave (
        input  enc_a, enc_b, clr,
        output pos, dir, step, err
    );
endinterface

// File: rtl/quad_decoder.sv
// quad_decoder
// Receiving end of a quadrature encoder link. Each channel is synchronised,
// glitch-filtered, and the filtered Gray-code pair is decoded into a step
// strobe, a direction and a wrapping up/down position count. An illegal
// transition (both channels changing together) sets a sticky error flag.
// Ports:
//   clk    : system clock, all state on the rising edge
//   resetn : asynchronous active-low reset
//   bus    : quad_decoder_if.slave (enc_a, enc_b, clr in; pos, dir, step, err out)
module quad_decoder #(
    parameter int POS_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic           clk,
    input  logic           resetn,
    quad_decoder_if.slave  bus
);

    // The decoder stays idle until the pipeline ahead of it has been filled
    // with real pin samples, so a resting encoder cannot look like a step.
    localparam int ARM_EDGES = SYNC_STAGES + FILT_LEN + 1;
    localparam int ARM_W     = $clog2(ARM_EDGES + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_EDGES - 1);

    typedef enum logic {
        ST_ARMING,
        ST_RUN
    } state_t;

    logic [SYNC_STAGES-1:0] syncA_q, syncB_q;
    logic [FILT_LEN-1:0]    histA_q, histB_q;
    logic                   fa_q, fb_q;
    logic                   fa_d, fb_d;

    state_t                 state_q, state_d;
    logic [ARM_W-1:0]       armCnt_q, armCnt_d;
    logic [1:0]             prev_q, prev_d;
    logic [POS_W-1:0]       pos_q, pos_d;
    logic                   dir_q, dir_d;
    logic                   step_q, step_d;
    logic                   err_q, err_d;

    logic [1:0]             cur;
    logic [1:0]             delta;

    // Maps a quadrature Gray code to its position within one electrical cycle
    // so that a legal step is a difference of +1 or -1 modulo 4.
    function automatic logic [1:0] grayToBin(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    // Plain flop chains: nothing may sit between the synchroniser stages.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            syncA_q <= '0;
            syncB_q <= '0;
        end else begin
            syncA_q <= {syncA_q[SYNC_STAGES-2:0], bus.enc_a};
            syncB_q <= {syncB_q[SYNC_STAGES-2:0], bus.enc_b};
        end
    end

    // Sample history of each synchronised channel for the glitch filter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            histA_q <= '0;
            histB_q <= '0;
        end else begin
            histA_q[0] <= syncA_q[SYNC_STAGES-1];
            histB_q[0] <= syncB_q[SYNC_STAGES-1];
            for (int i = 1; i < FILT_LEN; i++) begin
                histA_q[i] <= histA_q[i-1];
                histB_q[i] <= histB_q[i-1];
            end
        end
    end

    // A filtered level only flips once the whole history agrees on the
    // opposite level: a high level falls when every sample is low, a low
    // level rises when every sample is high.
    always_comb begin
        fa_d = fa_q ? (|histA_q) : (&histA_q);
        fb_d = fb_q ? (|histB_q) : (&histB_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fa_q <= 1'b0;
            fb_q <= 1'b0;
        end else begin
            fa_q <= fa_d;
            fb_q <= fb_d;
        end
    end

    assign cur   = {fa_q, fb_q};
    assign delta = grayToBin(cur) - grayToBin(prev_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_ARMING;
            armCnt_q <= '0;
            prev_q   <= 2'b00;
            pos_q    <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            armCnt_q <= armCnt_d;
            prev_q   <= prev_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            err_q    <= err_d;
        end
    end

    // On the arming edge the filtered level is itself still settling (it
    // takes its first real value on this very edge), so prev captures the
    // incoming filtered value rather than the stale reset value.
    always_comb begin
        state_d  = state_q;
        armCnt_d = armCnt_q;
        prev_d   = prev_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        step_d   = 1'b0;
        err_d    = err_q;

        case (state_q)
            ST_ARMING: begin
                armCnt_d = armCnt_q + ARM_W'(1);
                if (armCnt_q == ARM_LAST) begin
                    state_d = ST_RUN;
                    prev_d  = {fa_d, fb_d};
                end
            end
            ST_RUN: begin
                prev_d = cur;
                case (delta)
                    2'd1: begin
                        pos_d  = pos_q + POS_W'(1);
                        dir_d  = 1'b1;
                        step_d = 1'b1;
                    end
                    2'd3: begin
                        pos_d  = pos_q - POS_W'(1);
                        dir_d  = 1'b0;
                        step_d = 1'b1;
                    end
                    2'd2: begin
                        err_d = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            default: begin
                state_d = ST_ARMING;
            end
        endcase

        // Clear overrides any count or error change on the same edge.
        if (bus.clr) begin
            pos_d = '0;
            err_d = 1'b0;
        end
    end

    assign bus.pos  = pos_q;
    assign bus.dir  = dir_q;
    assign bus.step = step_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder
// Directed bench for quad_decoder. Each legal encoder transition driven pushes
// the expected pos/dir and the cycle its step pulse must appear on; a monitor
// records every observed step pulse, and the two queues are compared.
module tb_quad_decoder;

    localparam int POS_W   = 8;
    localparam int LATENCY = 7;

    typedef struct {
        logic [POS_W-1:0] pos;
        logic             dir;
        int               cycle;
    } stepRec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    quad_decoder_if #(.POS_W(POS_W)) bus ();

    quad_decoder #(
        .POS_W      (POS_W),
        .SYNC_STAGES(2),
        .FILT_LEN   (3)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int       cycleCnt = 0;
    stepRec_t expQ[$];
    stepRec_t obsQ[$];
    stepRec_t monRec;

    int nAsserts = 0;
    int nFail    = 0;

    logic [POS_W-1:0] modelPos;
    logic             modelDir;
    logic             modelErr;
    logic [1:0]       encState;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    always @(negedge clk) begin
        if (resetn && bus.step) begin
            monRec.pos   = bus.pos;
            monRec.dir   = bus.dir;
            monRec.cycle = cycleCnt;
            obsQ.push_back(monRec);
        end
    end

    function automatic logic [1:0] upNext(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a new {A,B} level at a falling edge and predict its effect.
    task automatic applyStimulus(input logic [1:0] ab, input int hold);
        stepRec_t e;
        bus.enc_a = ab[1];
        bus.enc_b = ab[0];
        if (ab == upNext(encState)) begin
            modelPos = modelPos + 8'd1;
            modelDir = 1'b1;
            e.pos = modelPos; e.dir = 1'b1; e.cycle = cycleCnt + LATENCY;
            expQ.push_back(e);
        end else if (encState == upNext(ab)) begin
            modelPos = modelPos - 8'd1;
            modelDir = 1'b0;
            e.pos = modelPos; e.dir = 1'b0; e.cycle = cycleCnt + LATENCY;
            expQ.push_back(e);
        end else if (ab != encState) begin
            modelErr = 1'b1;
        end
        encState = ab;
        repeat (hold) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        stepRec_t o, e;
        check({tag, ".stepCount"}, obsQ.size(), expQ.size());
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            o = obsQ.pop_front();
            e = expQ.pop_front();
            check({tag, ".stepPos"},   32'(o.pos), 32'(e.pos));
            check({tag, ".stepDir"},   32'(o.dir), 32'(e.dir));
            check({tag, ".stepCycle"}, o.cycle,    e.cycle);
        end
        obsQ.delete();
        expQ.delete();
        check({tag, ".pos"}, 32'(bus.pos), 32'(modelPos));
        check({tag, ".dir"}, 32'(bus.dir), 32'(modelDir));
        check({tag, ".err"}, 32'(bus.err), 32'(modelErr));
    endtask

    task automatic pulseClr();
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        modelPos = '0;
        modelErr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.enc_a = 1'b1;
        bus.enc_b = 1'b1;
        bus.clr   = 1'b0;
        encState  = 2'b11;
        modelPos  = '0;
        modelDir  = 1'b0;
        modelErr  = 1'b0;

        // Reset held with the encoder resting at 11
        repeat (3) @(negedge clk);
        check("reset.pos",  32'(bus.pos),  0);
        check("reset.dir",  32'(bus.dir),  0);
        check("reset.step", 32'(bus.step), 0);
        check("reset.err",  32'(bus.err),  0);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("restAt11");

        // Walk to 00 with two up steps, then clear a non-zero count
        applyStimulus(2'b10, 10);
        applyStimulus(2'b00, 10);
        checkOutput("toZero");
        pulseClr();
        checkOutput("clrPos");

        $display("[TB] up sequence");
        applyStimulus(2'b01, 10);
        applyStimulus(2'b11, 10);
        applyStimulus(2'b10, 10);
        applyStimulus(2'b00, 10);
        checkOutput("up4");

        $display("[TB] down sequence through zero");
        applyStimulus(2'b10, 10);
        applyStimulus(2'b11, 10);
        applyStimulus(2'b01, 10);
        applyStimulus(2'b00, 10);
        applyStimulus(2'b10, 10);
        applyStimulus(2'b11, 10);
        checkOutput("down6");

        // Up through 0xFF -> 0x00 back to rest at 00
        applyStimulus(2'b10, 10);
        applyStimulus(2'b00, 10);
        checkOutput("wrapUp");

        $display("[TB] short glitch on A");
        bus.enc_a = 1'b1;
        repeat (2) @(negedge clk);
        bus.enc_a = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("glitch");

        $display("[TB] illegal 00 -> 11");
        applyStimulus(2'b11, 15);
        checkOutput("illegal");
        pulseClr();
        checkOutput("clrErr");

        $display("[TB] reset mid-sequence");
        applyStimulus(2'b10, 10);
        applyStimulus(2'b00, 10);
        applyStimulus(2'b01, 10);
        applyStimulus(2'b11, 10);
        applyStimulus(2'b10, 10);
        checkOutput("up5");
        applyStimulus(2'b00, 3);
        #2 resetn = 1'b0;
        #1;
        check("midReset.pos",  32'(bus.pos),  0);
        check("midReset.dir",  32'(bus.dir),  0);
        check("midReset.step", 32'(bus.step), 0);
        check("midReset.err",  32'(bus.err),  0);
        expQ.delete();
        modelPos = '0;
        modelDir = 1'b0;
        modelErr = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("restAfterReset");
        applyStimulus(2'b01, 10);
        applyStimulus(2'b11, 10);
        applyStimulus(2'b10, 10);
        checkOutput("up3");
        pulseClr();
        checkOutput("clrFinal");

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
